// File: rtl/mem_pkg.sv
// Shared encodings for the M stage: access widths, writeback source select,
// bus FSM states and the alignment rule used to veto bus requests.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr[0];
            F3_W:        mis = |addr;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/halfword of a load word down to bit 0 and
// sign- or zero-extends it according to the access width.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_B:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H:  data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU: data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: runs one data-memory access at a time over a req/ready/rvalid
// bus, stalls the front of the pipe while it is outstanding, and fills MEM/WB.
module memory_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            DMemReq,
    output logic            DMemWe,
    output logic [XLEN-1:0] DMemAddr,
    output logic [XLEN-1:0] DMemWData,
    output logic [3:0]      DMemBe,
    input  logic            DMemReady,
    input  logic            DMemRValid,
    input  logic [XLEN-1:0] DMemRData,
    output logic            StallM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MisalignW,
    output logic            BusErrW
);

    localparam int              CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   LAST = CW'(MAX_WAIT - 1);

    mem_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_load, is_store, access, mis, go;
    logic            complete, timeout, req_raw;
    logic [XLEN-1:0] load_data;

    assign is_store = MemWriteM;
    assign is_load  = (ResultSrcM == RS_MEM) && !MemWriteM;
    assign access   = is_load | is_store;
    assign mis      = is_misaligned(Funct3M, ALUResultM[1:0]);
    assign go       = access & !mis;

    always_comb begin
        state_d  = state_q;
        req_raw  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    req_raw = 1'b1;
                    if (DMemReady) begin
                        if (is_store) complete = 1'b1;
                        else          state_d  = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req_raw = 1'b1;
                if (DMemReady) begin
                    if (is_store) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (DMemRValid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A real completion in the last allowed cycle wins over the abandon.
        if (state_q != IDLE && !complete && cnt_q == LAST) begin
            timeout = 1'b1;
            state_d = IDLE;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
    end

    assign StallM   = go & !complete & !timeout;
    assign DMemReq  = req_raw & rst_n;
    assign DMemWe   = is_store;
    assign DMemAddr = {ALUResultM[XLEN-1:2], 2'b00};

    always_comb begin
        DMemWData = WriteDataM;
        DMemBe    = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                DMemWData = {(XLEN/8){WriteDataM[7:0]}};
                DMemBe    = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                DMemWData = {(XLEN/16){WriteDataM[15:0]}};
                DMemBe    = 4'b0011 << ALUResultM[1:0];
            end
            default: begin
                DMemWData = WriteDataM;
                DMemBe    = 4'b1111;
            end
        endcase
    end

    load_align #(.XLEN(XLEN)) u_align (
        .rdata  (DMemRData),
        .addr   (ALUResultM[1:0]),
        .funct3 (Funct3M),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (StallM) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= '0;
                ALUResultW <= '0;
                ReadDataW  <= '0;
                RdW        <= '0;
                PCPlus4W   <= '0;
                MisalignW  <= 1'b0;
                BusErrW    <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM & !(access & mis) & !timeout;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                ReadDataW  <= (is_load & complete) ? load_data : '0;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
                MisalignW  <= access & mis;
                BusErrW    <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scenario bench for memory_stage: each task drives one feature, pushes the
// expected MEM/WB contents and compares them once the access completes.
`timescale 1ns/1ps
module tb_memory_stage;
    import mem_pkg::*;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;
    logic [31:0]     ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]      RdM;
    logic            DMemReq, DMemWe, DMemReady, DMemRValid, StallM;
    logic [31:0]     DMemAddr, DMemWData, DMemRData;
    logic [3:0]      DMemBe;
    logic            RegWriteW, MisalignW, BusErrW;
    logic [1:0]      ResultSrcW;
    logic [31:0]     ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]      RdW;

    memory_stage #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .DMemBe(DMemBe), .DMemReady(DMemReady),
        .DMemRValid(DMemRValid), .DMemRData(DMemRData), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        mis;
        logic        berr;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int          obs_stalls, obs_req_cycles, obs_bubble_bad;
    logic        obs_bus_stable, obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_addr;
    wb_t         obs_w;

    function automatic wb_t mk(input logic rw, input logic [1:0] rs, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [4:0] rd,
                               input logic [31:0] pc4, input logic mis, input logic berr);
        wb_t w;
        w.rw = rw; w.rs = rs; w.alu = alu; w.rdata = rdata;
        w.rd = rd; w.pc4 = pc4; w.mis = mis; w.berr = berr;
        return w;
    endfunction

    // Independent load model: pick lanes by offset rather than shifting.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:  return {{24{b[7]}}, b};
            F3_BU: return {24'h0, b};
            F3_H:  return {{16{h[15]}}, h};
            F3_HU: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic nop_inputs();
        RegWriteM = 0; ResultSrcM = RS_ALU; MemWriteM = 0; Funct3M = 0;
        ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
        DMemReady = 0; DMemRValid = 0;
    endtask

    // Drives one M-stage instruction starting at posedge+1 and responds on the bus:
    // Ready in cycle ready_lat (-1 = never), RValid rvalid_lat cycles later (0 = never).
    task automatic drive_txn(input logic rw, input logic [1:0] rs, input logic mw,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdat, input logic [4:0] rd,
                             input logic [31:0] pc4, input int ready_lat,
                             input int rvalid_lat, input logic [31:0] rword);
        logic seen;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wdat; RdM = rd; PCPlus4M = pc4;
        DMemRData = rword;
        obs_stalls = 0; obs_req_cycles = 0; obs_bubble_bad = 0;
        obs_bus_stable = 1; obs_be = 0; obs_wdata = 0; obs_addr = 0; obs_we = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            DMemReady  = (k == ready_lat);
            DMemRValid = (rvalid_lat > 0) && (k == ready_lat + rvalid_lat);
            #1;
            if (DMemReq === 1'b1) begin
                if (!seen) begin
                    obs_be = DMemBe; obs_wdata = DMemWData; obs_addr = DMemAddr;
                    obs_we = DMemWe; seen = 1;
                end else if (DMemBe !== obs_be || DMemWData !== obs_wdata ||
                             DMemAddr !== obs_addr) begin
                    obs_bus_stable = 0;
                end
                obs_req_cycles++;
            end
            if (StallM !== 1'b1) break;
            obs_stalls++;
            @(posedge clk); #1;
            if (RegWriteW !== 1'b0 || MisalignW !== 1'b0 || BusErrW !== 1'b0 || RdW !== 5'd0)
                obs_bubble_bad++;
        end
        @(posedge clk); #1;
        obs_w = mk(RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW);
        nop_inputs();
        $display("txn f3=%b rs=%b we=%b addr=%h stalls=%0d reqs=%0d -> rw=%b rd=%0d rdata=%h mis=%b berr=%b",
                 f3, rs, mw, addr, obs_stalls, obs_req_cycles, obs_w.rw, obs_w.rd,
                 obs_w.rdata, obs_w.mis, obs_w.berr);
    endtask

    // Pops the next expectation; ReadDataW is only meaningful for completed loads.
    task automatic pop_exp(output wb_t e, output wb_t g);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        g = obs_w;
        if (!(e.rs == RS_MEM && !e.mis && !e.berr)) g.rdata = e.rdata;
    endtask

    task automatic test_reset();
        wb_t e, g;
        rst_n = 0;
        nop_inputs();
        DMemRData = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0) begin
            errors++;
            $display("FAIL reset_w: got rw=%b rd=%0d alu=%h want all zero", RegWriteW, RdW, ALUResultW);
        end
        checks++;
        if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b stall=%b want 0 0", DMemReq, StallM);
        end
        rst_n = 1;
        @(posedge clk); #1;
        exp_q.push_back(mk(1, RS_ALU, 32'h55AA, 0, 5'd7, 32'h44, 0, 0));
        drive_txn(1, RS_ALU, 0, F3_W, 32'h55AA, 0, 5'd7, 32'h44, 0, 0, 0);
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL alu_pass: got %h want %h", g, e);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (RegWriteW !== 1'b0 || RdW !== 5'd0 || ALUResultW !== 32'h0 || PCPlus4W !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got rw=%b rd=%0d alu=%h want 0 0 0", RegWriteW, RdW, ALUResultW);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        wb_t e, g;
        exp_q.push_back(mk(1, RS_MEM, 32'h100, 32'hDEADBEEF, 5'd5, 32'h104, 0, 0));
        drive_txn(1, RS_MEM, 0, F3_W, 32'h100, 0, 5'd5, 32'h104, 0, 1, 32'hDEADBEEF);
        checks++;
        if (obs_stalls != 1) begin
            errors++;
            $display("FAIL lw_stalls: got %0d want 1", obs_stalls);
        end
        checks++;
        if (obs_req_cycles != 1 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus: got reqs=%0d addr=%h we=%b want 1 00000100 0", obs_req_cycles, obs_addr, obs_we);
        end
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL lw_wb: got %h want %h", g, e);
        end
    endtask

    task automatic test_subword();
        logic [2:0]  f3s  [8] = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU, F3_H, F3_B};
        logic [31:0] adrs [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h102, 32'h100, 32'h101};
        logic [31:0] exps [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                  32'h00000001, 32'h000000FF, 32'h00007F01, 32'h0000007F};
        wb_t e, g;
        int r, v;
        for (int i = 0; i < 8; i++) begin
            r = i % 2;
            v = 1 + (i % 2);
            exp_q.push_back(mk(1, RS_MEM, adrs[i], exps[i], 5'(i + 10), 32'h2000 + i, 0, 0));
            drive_txn(1, RS_MEM, 0, f3s[i], adrs[i], 0, 5'(i + 10), 32'h2000 + i, r, v, 32'h80FF7F01);
            checks++;
            if (obs_stalls != r + v || obs_addr !== 32'h100) begin
                errors++;
                $display("FAIL sub_timing[%0d]: got stalls=%0d addr=%h want %0d 00000100", i, obs_stalls, obs_addr, r + v);
            end
            pop_exp(e, g);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sub_wb[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s  [4] = '{F3_B, F3_H, F3_W, F3_B};
        logic [31:0] adrs [4] = '{32'h202, 32'h202, 32'h200, 32'h201};
        logic [31:0] dats [4] = '{32'h123456AB, 32'hFFFF1234, 32'hCAFEF00D, 32'h0000005C};
        int          lats [4] = '{3, 0, 1, 0};
        logic [3:0]  bes  [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b0010};
        logic [31:0] wds  [4] = '{32'hABABABAB, 32'h12341234, 32'hCAFEF00D, 32'h5C5C5C5C};
        wb_t e, g;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(0, RS_ALU, adrs[i], 0, 5'd0, 32'h300 + i, 0, 0));
            drive_txn(0, RS_ALU, 1, f3s[i], adrs[i], dats[i], 5'd0, 32'h300 + i, lats[i], 0, 32'hFFFFFFFF);
            checks++;
            if (obs_be !== bes[i] || obs_wdata !== wds[i] || obs_we !== 1'b1 || obs_addr !== 32'h200) begin
                errors++;
                $display("FAIL st_lanes[%0d]: got be=%b wd=%h we=%b addr=%h want be=%b wd=%h we=1 addr=00000200",
                         i, obs_be, obs_wdata, obs_we, obs_addr, bes[i], wds[i]);
            end
            checks++;
            if (obs_stalls != lats[i] || obs_req_cycles != lats[i] + 1 || !obs_bus_stable) begin
                errors++;
                $display("FAIL st_timing[%0d]: got stalls=%0d reqs=%0d stable=%b want %0d %0d 1",
                         i, obs_stalls, obs_req_cycles, obs_bus_stable, lats[i], lats[i] + 1);
            end
            checks++;
            if (obs_bubble_bad != 0) begin
                errors++;
                $display("FAIL st_bubble[%0d]: got %0d non-bubble cycles want 0", i, obs_bubble_bad);
            end
            pop_exp(e, g);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL st_wb[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s  [5] = '{F3_W, F3_H, F3_W, F3_HU, F3_H};
        logic [31:0] adrs [5] = '{32'h201, 32'h101, 32'h202, 32'h103, 32'h203};
        logic        sts  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        wb_t e, g;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(0, sts[i] ? RS_ALU : RS_MEM, adrs[i], 0, 5'd4, 32'h400, 1, 0));
            drive_txn(!sts[i], sts[i] ? RS_ALU : RS_MEM, sts[i], f3s[i], adrs[i], 32'h77, 5'd4,
                      32'h400, 0, 1, 32'h11111111);
            checks++;
            if (obs_req_cycles != 0 || obs_stalls != 0) begin
                errors++;
                $display("FAIL mis_bus[%0d]: got reqs=%0d stalls=%0d want 0 0", i, obs_req_cycles, obs_stalls);
            end
            pop_exp(e, g);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mis_wb[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_timeout();
        wb_t e, g;
        exp_q.push_back(mk(0, RS_MEM, 32'h300, 0, 5'd9, 32'h500, 0, 1));
        drive_txn(1, RS_MEM, 0, F3_W, 32'h300, 0, 5'd9, 32'h500, 0, 0, 32'h0BAD0BAD);
        checks++;
        if (obs_stalls != 4) begin
            errors++;
            $display("FAIL to_load_stalls: got %0d want 4", obs_stalls);
        end
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL to_load_wb: got %h want %h", g, e);
        end
        exp_q.push_back(mk(0, RS_ALU, 32'h304, 0, 5'd0, 32'h504, 0, 1));
        drive_txn(0, RS_ALU, 1, F3_W, 32'h304, 32'h1, 5'd0, 32'h504, -1, 0, 0);
        checks++;
        if (obs_stalls != 4) begin
            errors++;
            $display("FAIL to_store_stalls: got %0d want 4", obs_stalls);
        end
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL to_store_wb: got %h want %h", g, e);
        end
        exp_q.push_back(mk(1, RS_MEM, 32'h308, 32'h600DF00D, 5'd2, 32'h508, 0, 0));
        drive_txn(1, RS_MEM, 0, F3_W, 32'h308, 0, 5'd2, 32'h508, 0, 1, 32'h600DF00D);
        checks++;
        if (obs_stalls != 1) begin
            errors++;
            $display("FAIL to_recover_stalls: got %0d want 1", obs_stalls);
        end
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL to_recover_wb: got %h want %h", g, e);
        end
    endtask

    task automatic test_reset_mid();
        wb_t e, g;
        RegWriteM = 1; ResultSrcM = RS_MEM; MemWriteM = 0; Funct3M = F3_W;
        ALUResultM = 32'h500; RdM = 5'd3; PCPlus4M = 32'h600; DMemReady = 1;
        @(posedge clk); #1;
        DMemReady = 0;
        #1;
        checks++;
        if (StallM !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_stall: got %b want 1", StallM);
        end
        rst_n = 0;
        #1;
        checks++;
        if (DMemReq !== 1'b0 || {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b rw=%b rd=%0d want 0 and W zero", DMemReq, RegWriteW, RdW);
        end
        nop_inputs();
        #1 rst_n = 1;
        @(posedge clk); #1;
        DMemRValid = 1; DMemRData = 32'h12345678;
        @(posedge clk); #1;
        DMemRValid = 0;
        checks++;
        if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin
            errors++;
            $display("FAIL late_rvalid: got rw=%b rdata=%h want 0 00000000", RegWriteW, ReadDataW);
        end
        exp_q.push_back(mk(1, RS_MEM, 32'h504, 32'hFFFFFFA5, 5'd6, 32'h604, 0, 0));
        drive_txn(1, RS_MEM, 0, F3_B, 32'h504, 0, 5'd6, 32'h604, 0, 1, 32'h000000A5);
        checks++;
        if (obs_stalls != 1) begin
            errors++;
            $display("FAIL post_reset_stalls: got %0d want 1", obs_stalls);
        end
        pop_exp(e, g);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset_wb: got %h want %h", g, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        wb_t e, g;
        int kind, r, v, want_stalls;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] addr, word, wd, pc4;
        logic [4:0]  rd;
        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 3);
            r    = $urandom_range(0, 2);
            v    = $urandom_range(1, 2);
            word = $urandom();
            wd   = $urandom();
            pc4  = $urandom();
            rd   = 5'($urandom_range(1, 31));
            f3   = ld_f3[$urandom_range(0, 4)];
            off  = 2'($urandom_range(0, 3));
            if (f3 == F3_W) off = 2'd0;
            if ((f3 == F3_H || f3 == F3_HU) && off[0]) off[0] = 1'b0;
            addr = 32'h800 + ($urandom_range(0, 63) << 2) + off;
            case (kind)
                0: begin
                    addr = $urandom();
                    exp_q.push_back(mk(1, RS_ALU, addr, 0, rd, pc4, 0, 0));
                    drive_txn(1, RS_ALU, 0, F3_W, addr, wd, rd, pc4, r, v, word);
                    want_stalls = 0;
                end
                1: begin
                    exp_q.push_back(mk(1, RS_MEM, addr, exp_load(f3, off, word), rd, pc4, 0, 0));
                    drive_txn(1, RS_MEM, 0, f3, addr, wd, rd, pc4, r, v, word);
                    want_stalls = r + v;
                end
                2: begin
                    if (f3[2]) f3 = {1'b0, f3[1:0]};
                    exp_q.push_back(mk(0, RS_ALU, addr, 0, rd, pc4, 0, 0));
                    drive_txn(0, RS_ALU, 1, f3, addr, wd, rd, pc4, r, 0, word);
                    want_stalls = r;
                end
                default: begin
                    exp_q.push_back(mk(1, RS_PC4, addr, 0, rd, pc4, 0, 0));
                    drive_txn(1, RS_PC4, 0, F3_H, addr | 32'h1, wd, rd, pc4, r, v, word);
                    e = exp_q.pop_back();
                    e.alu = addr | 32'h1;
                    exp_q.push_back(e);
                    want_stalls = 0;
                end
            endcase
            checks++;
            if (obs_stalls != want_stalls) begin
                errors++;
                $display("FAIL b2b_stalls[%0d]: got %0d want %0d", i, obs_stalls, want_stalls);
            end
            pop_exp(e, g);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_wb[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw();
        test_subword();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
